// File: rtl/tdoa_capture.sv
// tdoa_capture: per-channel onset timestamping for hydrophone TDOA.
// Waits for the first threshold crossing on any channel, timestamps the
// first crossing of every channel within a bounded window, and reports the
// delays relative to REF_CH over a valid/ready handshake. After the result
// is accepted it ignores HOLDOFF_SAMPLES samples to reject reverberation.
//
// Handshake: tdoa_valid stays high, and tdoa_data/ch_mask/timeout_flag
// stay stable, until a cycle with tdoa_valid && tdoa_ready. That cycle is
// the transfer, and tdoa_valid is low on the following cycle.
module tdoa_capture #(
    parameter int NUM_CH          = 4,
    parameter int SAMPLE_W        = 12,
    parameter int CNT_W           = 16,
    parameter int REF_CH          = 0,
    parameter int HOLDOFF_SAMPLES = 256
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       arm,
    input  logic                       sample_valid,
    input  logic [NUM_CH*SAMPLE_W-1:0] sample_data,
    input  logic [SAMPLE_W-1:0]        threshold,
    input  logic [CNT_W-1:0]           window,
    output logic                       tdoa_valid,
    input  logic                       tdoa_ready,
    output logic [NUM_CH*CNT_W-1:0]    tdoa_data,
    output logic [NUM_CH-1:0]          ch_mask,
    output logic                       timeout_flag,
    output logic                       busy
);

    localparam int HW = (HOLDOFF_SAMPLES > 1) ? $clog2(HOLDOFF_SAMPLES + 1) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARMED,
        S_CAPTURE,
        S_DONE,
        S_HOLDOFF
    } state_t;

    state_t state, state_nxt;

    logic [CNT_W-1:0]        cnt;
    logic [CNT_W-1:0]        window_q;
    logic [NUM_CH-1:0]       work_mask;
    logic [CNT_W-1:0]        ts     [NUM_CH];
    logic [CNT_W-1:0]        ts_nxt [NUM_CH];
    logic [HW-1:0]           hold_cnt;

    logic [SAMPLE_W:0]       mag    [NUM_CH];
    logic [NUM_CH-1:0]       hit;
    logic [NUM_CH-1:0]       base_mask;
    logic [NUM_CH-1:0]       new_hit;
    logic [NUM_CH-1:0]       mask_nxt;
    logic [CNT_W-1:0]        cur;
    logic [CNT_W-1:0]        win_eff;
    logic                    all_set;
    logic                    expire;
    logic                    start;
    logic                    step;
    logic                    finish;
    logic                    hold_last;
    logic [NUM_CH*CNT_W-1:0] tdoa_nxt;

    // Magnitude at SAMPLE_W+1 bits so the most negative sample is exact.
    always_comb begin
        hit = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            mag[i] = {sample_data[i*SAMPLE_W + SAMPLE_W-1], sample_data[i*SAMPLE_W +: SAMPLE_W]};
            if (mag[i][SAMPLE_W]) begin
                mag[i] = -mag[i];
            end
            hit[i] = sample_valid && (mag[i] >= {1'b0, threshold});
        end
    end

    // Capture bookkeeping for the current sample; the first-hit sample
    // (in ARMED) starts from an empty mask at counter 0.
    always_comb begin
        base_mask = (state == S_ARMED) ? '0 : work_mask;
        cur       = (state == S_ARMED) ? '0 : cnt + CNT_W'(1);
        win_eff   = (state == S_ARMED) ? window : window_q;
        new_hit   = hit & ~base_mask;
        mask_nxt  = base_mask | new_hit;
        all_set   = &mask_nxt;
        expire    = (cur >= win_eff);
        start     = (state == S_ARMED) && arm && (|hit);
        step      = (state == S_CAPTURE) && sample_valid;
        finish    = (start || step) && (all_set || expire);
        hold_last = (hold_cnt == HW'(HOLDOFF_SAMPLES - 1));
        for (int i = 0; i < NUM_CH; i++) begin
            ts_nxt[i] = new_hit[i] ? cur : ((state == S_ARMED) ? '0 : ts[i]);
        end
        tdoa_nxt = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (mask_nxt[i] && mask_nxt[REF_CH]) begin
                tdoa_nxt[i*CNT_W +: CNT_W] = ts_nxt[i] - ts_nxt[REF_CH];
            end
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (arm) state_nxt = S_ARMED;
            end
            S_ARMED: begin
                if (!arm)        state_nxt = S_IDLE;
                else if (finish) state_nxt = S_DONE;
                else if (start)  state_nxt = S_CAPTURE;
            end
            S_CAPTURE: begin
                if (finish) state_nxt = S_DONE;
            end
            S_DONE: begin
                if (tdoa_ready) state_nxt = (HOLDOFF_SAMPLES == 0) ? S_IDLE : S_HOLDOFF;
            end
            S_HOLDOFF: begin
                if (sample_valid && hold_last) state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Timestamps, counters and registered result; result fields only
    // change on DONE entry so they hold through handshake and holdoff.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt          <= '0;
            window_q     <= '0;
            work_mask    <= '0;
            hold_cnt     <= '0;
            ch_mask      <= '0;
            timeout_flag <= 1'b0;
            tdoa_data    <= '0;
            for (int i = 0; i < NUM_CH; i++) ts[i] <= '0;
        end else begin
            if (start || step) begin
                cnt       <= cur;
                work_mask <= mask_nxt;
                for (int i = 0; i < NUM_CH; i++) ts[i] <= ts_nxt[i];
            end
            if (start) begin
                window_q <= window;
            end
            if (finish) begin
                ch_mask      <= mask_nxt;
                timeout_flag <= !all_set || !mask_nxt[REF_CH];
                tdoa_data    <= tdoa_nxt;
            end
            if (state == S_DONE && tdoa_ready) begin
                hold_cnt <= '0;
            end else if (state == S_HOLDOFF && sample_valid) begin
                hold_cnt <= hold_cnt + HW'(1);
            end
        end
    end

    assign tdoa_valid = (state == S_DONE);
    assign busy       = (state != S_IDLE);

endmodule

// File: tb/tb_tdoa_capture.sv
// Directed bench for tdoa_capture (NUM_CH=4, SAMPLE_W=12, CNT_W=16).
module tb_tdoa_capture;

    logic        clk;
    logic        rst_n;
    logic        arm;
    logic        sample_valid;
    logic [47:0] sample_data;
    logic [11:0] threshold;
    logic [15:0] window;
    logic        tdoa_valid;
    logic        tdoa_ready;
    logic [63:0] tdoa_data;
    logic [3:0]  ch_mask;
    logic        timeout_flag;
    logic        busy;

    int checks = 0;
    int errors = 0;

    tdoa_capture dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .arm          (arm),
        .sample_valid (sample_valid),
        .sample_data  (sample_data),
        .threshold    (threshold),
        .window       (window),
        .tdoa_valid   (tdoa_valid),
        .tdoa_ready   (tdoa_ready),
        .tdoa_data    (tdoa_data),
        .ch_mask      (ch_mask),
        .timeout_flag (timeout_flag),
        .busy         (busy)
    );

    // Clock and bench watchdog.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: time limit reached, got no finish, required finish");
        $fatal(1, "watchdog");
    end

    // One clock with the given sample inputs; returns #1 after the edge.
    task automatic step(input logic v, input logic [47:0] d);
        sample_valid = v;
        sample_data  = d;
        @(posedge clk);
        #1;
        sample_valid = 1'b0;
    endtask

    // Loud channels: ch0 +200, ch1 -200, ch2 +100, ch3 -100 (threshold 100).
    // Quiet channels sit at +/-99, just below threshold.
    function automatic logic [47:0] build(input logic [3:0] m);
        logic [47:0] f;
        f[11:0]  = m[0] ? 12'd200  : 12'd99;
        f[23:12] = m[1] ? 12'hF38  : 12'hF9D;
        f[35:24] = m[2] ? 12'd100  : 12'd99;
        f[47:36] = m[3] ? 12'hF9C  : 12'hF9D;
        return f;
    endfunction

    // Arms, then plays samples k=0.. with channel i loud from sample c_i on
    // (c_i<0 = never). Non-valid loud cycles are interleaved. Returns the
    // sample index after which tdoa_valid was seen, or -1.
    task automatic do_capture(input int c0, input int c1, input int c2, input int c3,
                              input int win, input int max_s, output int done_at);
        int c[4];
        logic [3:0] m;
        c[0] = c0; c[1] = c1; c[2] = c2; c[3] = c3;
        window = 16'(win);
        arm = 1'b1;
        step(1'b0, '0);
        step(1'b1, build(4'b0000));
        done_at = -1;
        for (int k = 0; k < max_s; k++) begin
            for (int i = 0; i < 4; i++) m[i] = (c[i] >= 0) && (k >= c[i]);
            step(1'b1, build(m));
            arm = 1'b0;
            if (tdoa_valid) begin
                done_at = k;
                break;
            end
            step(1'b0, build(4'b1111));
        end
    endtask

    // Accept the result, then walk through the holdoff with loud samples.
    task automatic accept_and_holdoff(input logic [3:0] exp_mask);
        tdoa_ready = 1'b1;
        step(1'b0, '0);
        tdoa_ready = 1'b0;
        checks++;
        if (tdoa_valid !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL handshake_drop: valid=%b busy=%b, required valid=0 busy=1", tdoa_valid, busy);
        end
        for (int k = 0; k < 255; k++) step(1'b1, build(4'b1111));
        checks++;
        if (busy !== 1'b1 || tdoa_valid !== 1'b0 || ch_mask !== exp_mask) begin
            errors++;
            $display("FAIL holdoff_255: busy=%b valid=%b mask=%b, required busy=1 valid=0 mask=%b",
                     busy, tdoa_valid, ch_mask, exp_mask);
        end
        step(1'b1, build(4'b1111));
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL holdoff_end: busy=%b, required 0", busy);
        end
    endtask

    task automatic test_reset;
        checks++;
        if (tdoa_valid !== 1'b0 || tdoa_data !== 64'd0 || ch_mask !== 4'd0 ||
            timeout_flag !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: valid=%b data=%h mask=%b to=%b busy=%b, required all 0",
                     tdoa_valid, tdoa_data, ch_mask, timeout_flag, busy);
        end
    endtask

    task automatic test_basic;
        int d;
        do_capture(0, 3, 7, 2, 50, 60, d);
        checks++;
        if (d !== 7) begin
            errors++;
            $display("FAIL basic_latency: valid after sample %0d, required 7", d);
        end
        checks++;
        if (tdoa_data !== {16'd2, 16'd7, 16'd3, 16'd0} || ch_mask !== 4'b1111 || timeout_flag !== 1'b0) begin
            errors++;
            $display("FAIL basic_result: data=%h mask=%b to=%b, required data=0002000700030000 mask=1111 to=0",
                     tdoa_data, ch_mask, timeout_flag);
        end
        accept_and_holdoff(4'b1111);
    endtask

    task automatic test_timeout;
        int d;
        do_capture(5, 9, 0, -1, 20, 40, d);
        checks++;
        if (d !== 20) begin
            errors++;
            $display("FAIL timeout_latency: valid after sample %0d, required 20", d);
        end
        checks++;
        if (tdoa_data !== {16'd0, 16'hFFFB, 16'd4, 16'd0} || ch_mask !== 4'b0111 || timeout_flag !== 1'b1) begin
            errors++;
            $display("FAIL timeout_result: data=%h mask=%b to=%b, required data=0000fffb00040000 mask=0111 to=1",
                     tdoa_data, ch_mask, timeout_flag);
        end
        accept_and_holdoff(4'b0111);
    endtask

    task automatic test_full_scale;
        threshold = 12'd2047;
        window = 16'd50;
        arm = 1'b1;
        step(1'b0, '0);
        step(1'b1, {12'h000, 12'h000, 12'h000, 12'h7FE});
        checks++;
        if (busy !== 1'b1 || tdoa_valid !== 1'b0) begin
            errors++;
            $display("FAIL below_full_scale: busy=%b valid=%b, required busy=1 valid=0", busy, tdoa_valid);
        end
        step(1'b1, {12'h800, 12'h801, 12'h7FF, 12'h800});
        arm = 1'b0;
        checks++;
        if (tdoa_valid !== 1'b1 || tdoa_data !== 64'd0 || ch_mask !== 4'b1111 || timeout_flag !== 1'b0) begin
            errors++;
            $display("FAIL full_scale: valid=%b data=%h mask=%b to=%b, required valid=1 data=0 mask=1111 to=0",
                     tdoa_valid, tdoa_data, ch_mask, timeout_flag);
        end
        threshold = 12'd100;
        accept_and_holdoff(4'b1111);
    endtask

    task automatic test_stall;
        int d;
        int bad;
        do_capture(0, 1, 2, 3, 50, 60, d);
        checks++;
        if (d !== 3) begin
            errors++;
            $display("FAIL stall_latency: valid after sample %0d, required 3", d);
        end
        bad = 0;
        for (int k = 0; k < 30; k++) begin
            arm = k[0];
            window = 16'(k);
            step(1'b1, build(4'b1111));
            checks++;
            if (tdoa_valid !== 1'b1 || tdoa_data !== {16'd3, 16'd2, 16'd1, 16'd0} ||
                ch_mask !== 4'b1111 || timeout_flag !== 1'b0) begin
                errors++;
                bad++;
                if (bad < 4)
                    $display("FAIL stall_hold cycle %0d: valid=%b data=%h mask=%b to=%b, required valid=1 data=0003000200010000 mask=1111 to=0",
                             k, tdoa_valid, tdoa_data, ch_mask, timeout_flag);
            end
        end
        arm = 1'b0;
        accept_and_holdoff(4'b1111);
    endtask

    task automatic test_window_edge;
        int d;
        do_capture(0, 2, 4, 10, 10, 20, d);
        checks++;
        if (d !== 10 || tdoa_data !== {16'd10, 16'd4, 16'd2, 16'd0} ||
            ch_mask !== 4'b1111 || timeout_flag !== 1'b0) begin
            errors++;
            $display("FAIL window_edge: at=%0d data=%h mask=%b to=%b, required at=10 data=000a000400020000 mask=1111 to=0",
                     d, tdoa_data, ch_mask, timeout_flag);
        end
        accept_and_holdoff(4'b1111);
    endtask

    task automatic test_ref_missing;
        int d;
        do_capture(-1, 0, 1, 2, 5, 20, d);
        checks++;
        if (d !== 5 || tdoa_data !== 64'd0 || ch_mask !== 4'b1110 || timeout_flag !== 1'b1) begin
            errors++;
            $display("FAIL ref_missing: at=%0d data=%h mask=%b to=%b, required at=5 data=0 mask=1110 to=1",
                     d, tdoa_data, ch_mask, timeout_flag);
        end
        accept_and_holdoff(4'b1110);
    endtask

    task automatic test_window_zero;
        int d;
        do_capture(0, -1, -1, 1, 0, 10, d);
        checks++;
        if (d !== 0 || tdoa_data !== 64'd0 || ch_mask !== 4'b0001 || timeout_flag !== 1'b1) begin
            errors++;
            $display("FAIL window_zero: at=%0d data=%h mask=%b to=%b, required at=0 data=0 mask=0001 to=1",
                     d, tdoa_data, ch_mask, timeout_flag);
        end
        accept_and_holdoff(4'b0001);
    endtask

    task automatic test_reset_mid;
        int d;
        window = 16'd50;
        arm = 1'b1;
        step(1'b0, '0);
        step(1'b1, build(4'b0001));
        arm = 1'b0;
        rst_n = 1'b0;
        step(1'b0, '0);
        rst_n = 1'b1;
        checks++;
        if (tdoa_valid !== 1'b0 || tdoa_data !== 64'd0 || ch_mask !== 4'd0 ||
            timeout_flag !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_capture: valid=%b data=%h mask=%b to=%b busy=%b, required all 0",
                     tdoa_valid, tdoa_data, ch_mask, timeout_flag, busy);
        end
        do_capture(0, 0, 0, 0, 50, 5, d);
        checks++;
        if (d !== 0 || tdoa_valid !== 1'b1 || ch_mask !== 4'b1111) begin
            errors++;
            $display("FAIL reset_setup: at=%0d valid=%b mask=%b, required at=0 valid=1 mask=1111",
                     d, tdoa_valid, ch_mask);
        end
        rst_n = 1'b0;
        step(1'b0, '0);
        rst_n = 1'b1;
        checks++;
        if (tdoa_valid !== 1'b0 || tdoa_data !== 64'd0 || ch_mask !== 4'd0 ||
            timeout_flag !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_done: valid=%b data=%h mask=%b to=%b busy=%b, required all 0",
                     tdoa_valid, tdoa_data, ch_mask, timeout_flag, busy);
        end
    endtask

    initial begin
        rst_n        = 1'b0;
        arm          = 1'b0;
        sample_valid = 1'b0;
        sample_data  = '0;
        threshold    = 12'd100;
        window       = 16'd50;
        tdoa_ready   = 1'b0;
        step(1'b0, '0);
        step(1'b0, '0);
        rst_n = 1'b1;
        test_reset;
        test_basic;
        test_timeout;
        test_full_scale;
        test_stall;
        test_ref_missing;
        test_window_zero;
        test_reset_mid;
        test_window_edge;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/tdoa_capture.md
Name: tdoa_capture

Overview:
- Parametrised, N-channel onset-timestamping block between hydrophone sample conditioning and TDOA/triangulation.
- Detects the first threshold crossing on each channel within a bounded capture window.
- Reports per-channel signed arrival delays relative to a reference channel over a valid/ready handshake, then holds off to reject reverberation.
- Generalises the fixed 4-channel TDOA path in channel count, sample width, timestamp width, window and holdoff.

Parameters:
- NUM_CH, 4, number of hydrophone channels (2..8).
- SAMPLE_W, 12, signed two's-complement sample width.
- CNT_W, 16, timestamp/delay width; window must be < 2^(CNT_W-1).
- REF_CH, 0, reference channel index for delays.
- HOLDOFF_SAMPLES, 256, samples ignored after a result is accepted.

Ports:
- clk, input, 1, system clock.
- rst_n, input, 1, synchronous active-low reset.
- arm, input, 1, level; enables detection.
- sample_valid, input, 1, one sample per channel this cycle.
- sample_data, input, NUM_CH*SAMPLE_W, packed samples; channel i at bits [i*SAMPLE_W +: SAMPLE_W].
- threshold, input, SAMPLE_W, unsigned magnitude threshold.
- window, input, CNT_W, capture window length in samples.
- tdoa_valid, output, 1, result available.
- tdoa_ready, input, 1, consumer accepts the result.
- tdoa_data, output, NUM_CH*CNT_W, signed delay ts[i]-ts[REF_CH], packed like sample_data.
- ch_mask, output, NUM_CH, bit i = channel i crossed within the window.
- timeout_flag, output, 1, window expired before all channels crossed.
- busy, output, 1, state != IDLE.

Behaviour:
- Clock and reset: one clock (clk); rst_n is synchronous, active-low.
- Reset: state IDLE; tdoa_valid=0, tdoa_data=0, ch_mask=0, timeout_flag=0, busy=0; all timestamps, counters and latches cleared. Reset asserted in any state, including mid-capture or with tdoa_valid high, discards all work.
- Magnitude: |x| computed at SAMPLE_W+1 bits, so the most negative value is handled correctly. A crossing is |x| >= threshold, evaluated only on cycles with sample_valid=1.
- IDLE -> ARMED when arm=1 (next cycle).
- ARMED:
  - arm=0 -> IDLE.
  - First sample_valid with at least one crossing -> CAPTURE. The sample counter is set to 0 at that sample, and window is latched at that point.
  - Every channel crossing on that sample gets timestamp 0 and its mask bit set.
- CAPTURE:
  - arm is ignored.
  - The counter increments on each sample_valid.
  - A channel's timestamp latches the counter value at its first crossing; later crossings on that channel are ignored.
  - All channels set -> DONE with timeout_flag=0.
  - Otherwise, when the counter reaches the latched window value -> DONE with timeout_flag=1.
  - A crossing on the same sample that the counter reaches window still counts. If it completes the mask, timeout_flag=0.
  - window=0: only the first-hit sample counts.
- DONE:
  - On the entry cycle, tdoa_data is registered, so tdoa_valid asserts 1 cycle after the completing sample.
  - For masked-in channels, tdoa_data[i] = ts[i]-ts[REF_CH] at CNT_W bits, signed.
  - Missing channels read 0.
  - If ch_mask[REF_CH]=0, all tdoa_data fields read 0 and timeout_flag=1.
  - tdoa_valid, tdoa_data, ch_mask and timeout_flag hold stable until tdoa_valid && tdoa_ready.
  - On that handshake cycle -> HOLDOFF; tdoa_valid drops the next cycle.
- HOLDOFF: count HOLDOFF_SAMPLES sample_valid cycles, then -> IDLE. Crossings are ignored during HOLDOFF. HOLDOFF_SAMPLES=0 -> IDLE immediately.
- Outputs after handshake: ch_mask, timeout_flag and tdoa_data keep their last values until the next DONE entry or reset.
- busy: 1 in ARMED, CAPTURE, DONE and HOLDOFF.

Test Plan:
- NUM_CH=4, threshold=100, window=50. Channels cross at samples 0,3,7,2 (ch0 first) -> tdoa_valid 1 cycle after sample 7; tdoa_data = {0,3,7,2}; ch_mask=4'b1111; timeout_flag=0.
- Ch2 first at sample 0, ch0 at 5, ch1 at 9, ch3 never, window=20 -> completes at counter 20; tdoa = {0,4,-5,0}; ch_mask=4'b0111; timeout_flag=1.
- All channels cross on the same sample; one sample is 0x800 (-2048) with threshold 2047 -> all tdoa 0; mask 4'b1111.
- tdoa_ready held low 30 cycles -> tdoa_valid and data stable for all 30 cycles; a crossing injected meanwhile has no effect. Ready pulse -> 256 ignored samples, then re-arm.
- window=10, last channel crosses exactly at counter 10 -> counted; timeout_flag=0.
- rst_n low for 1 cycle during CAPTURE and during DONE with valid high -> next cycle all outputs 0, busy=0; a subsequent capture is correct.
